// File: rtl/simon_stream_ctrl.sv
// ---------------------------------------------------------------------------
// simon_stream_ctrl
//   Stream front/back end for an unrolled Simon 32/64 pipeline. Takes keys and
//   plaintext blocks over valid/ready and drives the pipeline's advance enable,
//   key and plaintext inputs. A shift register tracks which pipeline slots hold
//   real blocks. Finished blocks go into a small first-word-fall-through FIFO.
//   The whole pipeline stalls when a finished block has nowhere to go.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   key_valid/key_in   key offer (64b); key_ready accepts it
//   pt_valid/pt_data   plaintext offer (32b); pt_ready accepts it
//   ct_valid/ct_data   FIFO head; ct_ready pops it
//   pipe_start         pipeline advance enable
//   pipe_keytext       registered key for the pipeline key schedule
//   pipe_plaintext     accepted block, or 0 when the slot is a bubble
//   pipe_ciphertext    pipeline output register
// ---------------------------------------------------------------------------
module simon_stream_ctrl #(
   parameter int PIPE_DEPTH       = 33,
   parameter int FIFO_DEPTH       = 4,
   parameter int KEY_SETUP_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [63:0] key_in,
   output logic        key_ready,
   input  logic        pt_valid,
   input  logic [31:0] pt_data,
   output logic        pt_ready,
   output logic        ct_valid,
   output logic [31:0] ct_data,
   input  logic        ct_ready,
   output logic        pipe_start,
   output logic [63:0] pipe_keytext,
   output logic [31:0] pipe_plaintext,
   input  logic [31:0] pipe_ciphertext
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(KEY_SETUP_CYCLES) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_KEY   = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PIPE_DEPTH-1:0] tag_q;
   logic [63:0]           key_q;
   logic [31:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wptr_q, rptr_q;
   logic [AW:0]           count_q;

   logic fifo_full, pop, push, stall, advance, pt_acc, key_acc;

   assign fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
   assign ct_valid  = (count_q != '0);
   assign ct_data   = mem_q[rptr_q];
   assign pop       = ct_valid && ct_ready;

   // Only a finished block that cannot be stored holds the pipeline; a pop in
   // the same cycle frees the slot it needs.
   assign stall   = tag_q[PIPE_DEPTH-1] && fifo_full && !pop;
   assign advance = (state_q == S_KEY) ||
                    (((state_q == S_RUN) || (state_q == S_DRAIN)) && !stall);

   assign pipe_start     = advance;
   assign pt_ready       = (state_q == S_RUN) && advance;
   assign pt_acc         = pt_valid && pt_ready;
   assign pipe_plaintext = pt_acc ? pt_data : '0;
   assign pipe_keytext   = key_q;

   // A new key is only taken once no real block is left in the pipeline.
   assign key_ready = (state_q == S_IDLE) || ((state_q == S_DRAIN) && (tag_q == '0));
   assign key_acc   = key_valid && key_ready;

   // Push only on an advance, so a result is stored once before it shifts out.
   assign push = tag_q[PIPE_DEPTH-1] && advance;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (key_acc) begin
               state_d = S_KEY;
               cnt_d   = '0;
            end
         end
         S_KEY: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(KEY_SETUP_CYCLES - 1)) state_d = S_RUN;
         end
         S_RUN: begin
            if (key_valid) state_d = S_DRAIN;
         end
         default: begin // S_DRAIN
            if (key_acc) begin
               state_d = S_KEY;
               cnt_d   = '0;
            end else if (!key_valid) begin
               state_d = S_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tag_q   <= '0;
         key_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (key_acc) key_q <= key_in;
         if (advance) tag_q <= {tag_q[PIPE_DEPTH-2:0], pt_acc};
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; count_q decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= pipe_ciphertext;
   end

endmodule

// File: tb/tb_simon_stream_ctrl.sv
module tb_simon_stream_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        key_valid = 1'b0, pt_valid = 1'b0, ct_ready = 1'b0;
   logic [63:0] key_in = '0;
   logic [31:0] pt_data = '0;
   logic        key_ready, pt_ready, ct_valid, pipe_start;
   logic [31:0] ct_data, pipe_plaintext, pipe_ciphertext;
   logic [63:0] pipe_keytext;

   localparam logic [63:0] KA = 64'h1918111009080100;
   localparam logic [63:0] KB = 64'h0123456789abcdef;

   int checks = 0, errors = 0, cycle = 0, cur_cyc = 0;
   logic [31:0] got_q[$];
   int          got_cyc[$];
   logic        key_acc_seen;

   simon_stream_ctrl dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
      .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
      .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
      .pipe_start(pipe_start), .pipe_keytext(pipe_keytext),
      .pipe_plaintext(pipe_plaintext), .pipe_ciphertext(pipe_ciphertext)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Behavioural Simon 32/64 encryption.
   function automatic logic [31:0] simon_enc(input logic [31:0] pt, input logic [63:0] key);
      logic [15:0] k [32];
      logic [15:0] x, y, t;
      logic [61:0] z;
      z = 62'b11111010001001010110000111001101111101000100101011000011100110;
      for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
      for (int i = 4; i < 32; i++) begin
         t = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
         t = t ^ {t[0], t[15:1]};
         k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
      end
      x = pt[31:16];
      y = pt[15:0];
      for (int i = 0; i < 32; i++) begin
         t = x;
         x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
         y = t;
      end
      return {x, y};
   endfunction

   // 33-slot pipeline model advancing on pipe_start.
   logic [31:0] stg [33];
   always @(posedge clk) begin
      if (pipe_start) begin
         for (int i = 32; i > 0; i--) stg[i] <= stg[i-1];
         stg[0] <= simon_enc(pipe_plaintext, pipe_keytext);
      end
   end
   assign pipe_ciphertext = stg[32];

   // One cycle: drive, sample mid-cycle, then cross the edge.
   task automatic step(input logic pv, input logic [31:0] pd, input logic cr, output logic acc);
      pt_valid = pv; pt_data = pd; ct_ready = cr;
      #1;
      acc = pv && pt_ready;
      key_acc_seen = key_valid && key_ready;
      cur_cyc = cycle;
      if (ct_valid && ct_ready) begin
         got_q.push_back(ct_data);
         got_cyc.push_back(cycle);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic cr);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, cr, a);
   endtask

   task automatic test_reset;
      logic a;
      rst = 1'b1;
      step(1'b0, 32'd0, 1'b1, a);
      step(1'b0, 32'd0, 1'b1, a);
      checks++; if (ct_valid !== 1'b0) begin errors++; $display("FAIL rst_ct_valid got %b exp 0", ct_valid); end
      checks++; if (pt_ready !== 1'b0) begin errors++; $display("FAIL rst_pt_ready got %b exp 0", pt_ready); end
      checks++; if (pipe_start !== 1'b0) begin errors++; $display("FAIL rst_pipe_start got %b exp 0", pipe_start); end
      checks++; if (pipe_keytext !== 64'd0) begin errors++; $display("FAIL rst_keytext got %h exp 0", pipe_keytext); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready got %b exp 1", key_ready); end
      rst = 1'b0;
   endtask

   task automatic test_single;
      logic a;
      int n, t;
      got_q.delete(); got_cyc.delete();
      key_valid = 1'b1; key_in = KA;
      step(1'b0, 32'd0, 1'b1, a);
      key_valid = 1'b0;
      checks++; if (key_acc_seen !== 1'b1) begin errors++; $display("FAIL key_accept got %b exp 1", key_acc_seen); end
      checks++; if (pipe_keytext !== KA) begin errors++; $display("FAIL keytext got %h exp %h", pipe_keytext, KA); end
      checks++; if (pipe_start !== 1'b1 || pt_ready !== 1'b0) begin errors++; $display("FAIL setup_ctl got start=%b rdy=%b exp 1 0", pipe_start, pt_ready); end
      n = 0;
      for (int c = 0; c < 100; c++) begin
         step(1'b1, 32'h65656877, 1'b1, a);
         if (a) break;
         n++;
      end
      t = cur_cyc;
      checks++; if (n != 32) begin errors++; $display("FAIL setup_cycles got %0d exp 32", n); end
      idle(40, 1'b1);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         checks++; if (got_q[0] !== 32'hc69be9bb) begin errors++; $display("FAIL single_ct got %h exp c69be9bb", got_q[0]); end
         checks++; if (got_cyc[0] - t != 34) begin errors++; $display("FAIL single_latency got %0d exp 34", got_cyc[0] - t); end
      end
   endtask

   task automatic test_back_to_back;
      logic a;
      logic [31:0] p [36];
      int idx, drops, t0;
      got_q.delete(); got_cyc.delete();
      for (int i = 0; i < 36; i++) p[i] = 32'h0f1e2d3c ^ (i * 32'h01234567);
      idx = 0; drops = 0; t0 = 0;
      for (int c = 0; c < 100 && idx < 36; c++) begin
         step(1'b1, p[idx], 1'b1, a);
         if (a) begin
            if (idx == 0) t0 = cur_cyc;
            idx++;
         end else drops++;
      end
      idle(40, 1'b1);
      checks++; if (drops != 0) begin errors++; $display("FAIL b2b_drops got %0d exp 0", drops); end
      checks++; if (got_q.size() != 36) begin errors++; $display("FAIL b2b_count got %0d exp 36", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 36; i++) begin
         checks++; if (got_q[i] !== simon_enc(p[i], KA)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[i], simon_enc(p[i], KA)); end
         checks++; if (got_cyc[i] != t0 + 34 + i) begin errors++; $display("FAIL b2b_cycle[%0d] got %0d exp %0d", i, got_cyc[i], t0 + 34 + i); end
      end
   endtask

   logic [31:0] bp [10];

   task automatic test_backpressure;
      logic a;
      int idx;
      got_q.delete(); got_cyc.delete();
      for (int i = 0; i < 10; i++) bp[i] = 32'hc0de0000 + i * 32'h00010003;
      idx = 0;
      for (int c = 0; c < 50 && idx < 10; c++) begin
         step(1'b1, bp[idx], 1'b0, a);
         if (a) idx++;
      end
      checks++; if (idx != 10) begin errors++; $display("FAIL bp_accepted got %0d exp 10", idx); end
      idle(40, 1'b0);
      checks++; if (ct_valid !== 1'b1) begin errors++; $display("FAIL bp_ct_valid got %b exp 1", ct_valid); end
      checks++; if (ct_data !== simon_enc(bp[0], KA)) begin errors++; $display("FAIL bp_head got %h exp %h", ct_data, simon_enc(bp[0], KA)); end
      checks++; if (pipe_start !== 1'b0) begin errors++; $display("FAIL bp_stall_start got %b exp 0", pipe_start); end
      checks++; if (pt_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b exp 0", pt_ready); end
   endtask

   task automatic test_full_push_pop;
      logic a;
      step(1'b0, 32'd0, 1'b1, a);   // pop b0 while b4 is pushed into the full FIFO
      ct_ready = 1'b0;
      #1;
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL fpp_pops got %0d exp 1", got_q.size()); end
      checks++; if (pipe_start !== 1'b0) begin errors++; $display("FAIL fpp_refull got %b exp 0", pipe_start); end
      checks++; if (ct_data !== simon_enc(bp[1], KA)) begin errors++; $display("FAIL fpp_head got %h exp %h", ct_data, simon_enc(bp[1], KA)); end
      idle(50, 1'b1);
      checks++; if (got_q.size() != 10) begin errors++; $display("FAIL fpp_count got %0d exp 10", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 10; i++) begin
         checks++; if (got_q[i] !== simon_enc(bp[i], KA)) begin errors++; $display("FAIL fpp_data[%0d] got %h exp %h", i, got_q[i], simon_enc(bp[i], KA)); end
      end
      for (int i = 2; i < got_cyc.size() && i < 10; i++) begin
         checks++; if (got_cyc[i] != got_cyc[1] + i - 1) begin errors++; $display("FAIL fpp_cycle[%0d] got %0d exp %0d", i, got_cyc[i], got_cyc[1] + i - 1); end
      end
   endtask

   task automatic test_rekey;
      logic a;
      logic [31:0] pa [5];
      logic [31:0] pb [3];
      int idx, n, t0, viol;
      got_q.delete(); got_cyc.delete();
      for (int i = 0; i < 5; i++) pa[i] = 32'h11110000 + i;
      for (int i = 0; i < 3; i++) pb[i] = 32'h22220000 + i;
      idx = 0; t0 = 0;
      for (int c = 0; c < 20 && idx < 5; c++) begin
         step(1'b1, pa[idx], 1'b1, a);
         if (a) begin
            if (idx == 0) t0 = cur_cyc;
            idx++;
         end
      end
      key_valid = 1'b1; key_in = KB;
      step(1'b0, 32'd0, 1'b1, a);
      n = 0; viol = 0;
      for (int c = 0; c < 100; c++) begin
         step(1'b1, 32'hdeadbeef, 1'b1, a);
         if (a) viol++;
         if (key_acc_seen) break;
         n++;
      end
      key_valid = 1'b0;
      checks++; if (viol != 0) begin errors++; $display("FAIL rk_pt_in_drain got %0d exp 0", viol); end
      checks++; if (n != 32) begin errors++; $display("FAIL rk_key_ready_wait got %0d exp 32", n); end
      checks++; if (cur_cyc != t0 + 38) begin errors++; $display("FAIL rk_key_cycle got %0d exp %0d", cur_cyc, t0 + 38); end
      checks++; if (pipe_keytext !== KB) begin errors++; $display("FAIL rk_keytext got %h exp %h", pipe_keytext, KB); end
      checks++; if (got_q.size() != 5) begin errors++; $display("FAIL rk_old_count got %0d exp 5", got_q.size()); end
      n = 0; idx = 0;
      for (int c = 0; c < 100 && idx < 3; c++) begin
         step(1'b1, pb[idx], 1'b1, a);
         if (a) idx++;
         else if (idx == 0) n++;
      end
      checks++; if (n != 32) begin errors++; $display("FAIL rk_setup_cycles got %0d exp 32", n); end
      idle(40, 1'b1);
      checks++; if (got_q.size() != 8) begin errors++; $display("FAIL rk_count got %0d exp 8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         logic [31:0] e;
         e = (i < 5) ? simon_enc(pa[i], KA) : simon_enc(pb[i-5], KB);
         checks++; if (got_q[i] !== e) begin errors++; $display("FAIL rk_data[%0d] got %h exp %h", i, got_q[i], e); end
      end
   endtask

   task automatic test_reset_midstream;
      logic a;
      int idx, n, t0;
      got_q.delete(); got_cyc.delete();
      idx = 0; t0 = 0;
      for (int c = 0; c < 30 && idx < 12; c++) begin
         step(1'b1, 32'h33330000 + idx, 1'b0, a);
         if (a) begin
            if (idx == 0) t0 = cur_cyc;
            idx++;
         end
      end
      for (int c = 0; c < 60 && cycle < t0 + 35; c++) idle(1, 1'b0);
      checks++; if (ct_valid !== 1'b1) begin errors++; $display("FAIL rm_fifo_loaded got %b exp 1", ct_valid); end
      rst = 1'b1;
      step(1'b0, 32'd0, 1'b0, a);
      checks++; if (ct_valid !== 1'b0) begin errors++; $display("FAIL rm_ct_valid got %b exp 0", ct_valid); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rm_key_ready got %b exp 1", key_ready); end
      checks++; if (pipe_start !== 1'b0) begin errors++; $display("FAIL rm_pipe_start got %b exp 0", pipe_start); end
      rst = 1'b0;
      key_valid = 1'b1; key_in = KA;
      step(1'b0, 32'd0, 1'b1, a);
      key_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         step(1'b1, 32'h65656877, 1'b1, a);
         if (a) break;
         n++;
      end
      checks++; if (n != 32) begin errors++; $display("FAIL rm_setup_cycles got %0d exp 32", n); end
      idle(45, 1'b1);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rm_count got %0d exp 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         checks++; if (got_q[0] !== 32'hc69be9bb) begin errors++; $display("FAIL rm_ct got %h exp c69be9bb", got_q[0]); end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_full_push_pop;
      test_rekey;
      test_reset_midstream;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
